// File: rtl/keypad_pkg.sv
// Shared keypad definitions: matrix size, keycode field split and emulator FSM encoding.
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    // keycode = {row index, column index}
    localparam int ROW_HI = 3;
    localparam int ROW_LO = 2;
    localparam int COL_HI = 1;
    localparam int COL_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BOUNCE  = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } kp_state_e;

    function automatic int kp_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/keypad_emu_timer.sv
// Loadable down-counter with a zero flag; one instance times every emulator phase.
module keypad_emu_timer #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/keypad_emulator.sv
// Keypad switch-matrix emulator: presses one key for HOLD_CYCLES, releases for GAP_CYCLES.
// Define KEYPAD_EMU_BOUNCE_EN to add a contact-bounce phase before the stable hold.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES   = 1000000,
    parameter int GAP_CYCLES    = 500000,
    parameter int BOUNCE_PERIOD = 5000,
    parameter int BOUNCE_EDGES  = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       contact,
    output logic       busy,
    output logic       done
);

    localparam int CNT_MAX = kp_max(kp_max(HOLD_CYCLES, GAP_CYCLES), BOUNCE_PERIOD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || BOUNCE_PERIOD < 1 ||
        BOUNCE_EDGES < 2 || (BOUNCE_EDGES % 2) != 0) begin : g_bad_params
        $error("keypad_emulator: invalid cycle parameters");
    end

    kp_state_e  state_q, state_d;
    logic [3:0] code_q, code_d;
    logic       contact_q, contact_d;
    logic       done_q, done_d;
    logic       tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic       tmr_zero;

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int EDGE_W = $clog2(BOUNCE_EDGES + 1);
    logic [EDGE_W-1:0] edges_q, edges_d;
`endif

    keypad_emu_timer #(.W(CNT_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
            edges_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            contact_q <= contact_d;
            done_q    <= done_d;
`ifdef KEYPAD_EMU_BOUNCE_EN
            edges_q   <= edges_d;
`endif
        end
    end

    // Each phase loads N-1 on entry and leaves on the cycle the count reads zero.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        contact_d = contact_q;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
`ifdef KEYPAD_EMU_BOUNCE_EN
        edges_d   = edges_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    code_d    = key_code;
                    contact_d = 1'b1;
                    tmr_load  = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
                    state_d   = ST_BOUNCE;
                    tmr_val   = CNT_W'(BOUNCE_PERIOD - 1);
                    edges_d   = EDGE_W'(BOUNCE_EDGES);
`else
                    state_d   = ST_HOLD;
                    tmr_val   = CNT_W'(HOLD_CYCLES - 1);
`endif
                end
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            ST_BOUNCE: begin
                if (tmr_zero) begin
                    contact_d = ~contact_q;
                    tmr_load  = 1'b1;
                    // Edge count is even, so the last toggle always lands closed.
                    if (edges_q == EDGE_W'(1)) begin
                        state_d = ST_HOLD;
                        edges_d = '0;
                        tmr_val = CNT_W'(HOLD_CYCLES - 1);
                    end else begin
                        edges_d = edges_q - 1'b1;
                        tmr_val = CNT_W'(BOUNCE_PERIOD - 1);
                    end
                end
            end
`endif
            ST_HOLD: begin
                if (tmr_zero) begin
                    state_d   = ST_RELEASE;
                    contact_d = 1'b0;
                    tmr_load  = 1'b1;
                    tmr_val   = CNT_W'(GAP_CYCLES - 1);
                end
            end
            ST_RELEASE: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                contact_d = 1'b0;
            end
        endcase
    end

    // Row sense behaves like a real closed contact bridging one row to one column.
    always_comb begin
        key_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        contact   = contact_q;
        done      = done_q;
        row       = '1;
        for (int r = 0; r < KP_ROWS; r++) begin
            if (contact_q && code_q[ROW_HI:ROW_LO] == r[1:0] && !col[code_q[COL_HI:COL_LO]]) begin
                row[r] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator (HOLD=8, GAP=4, BOUNCE_PERIOD=2, BOUNCE_EDGES=4).
module tb_keypad_emulator;

    logic       clock;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [3:0] col;
    logic [3:0] row;
    logic       contact;
    logic       busy;
    logic       done;

    int tests_run;
    int tests_failed;

    keypad_emulator #(
        .HOLD_CYCLES   (8),
        .GAP_CYCLES    (4),
        .BOUNCE_PERIOD (2),
        .BOUNCE_EDGES  (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .col       (col),
        .row       (row),
        .contact   (contact),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clock);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!key_ready && n < 64) begin
            step();
            n++;
        end
        tests_run++;
        if (!key_ready) begin
            tests_failed++;
            $display("FAIL %s_idle_timeout: key_ready=%b required 1", tag, key_ready);
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; key_valid = 1'b0; key_code = 4'h0; col = 4'b1111;
        step(); step();
        reset = 1'b0;
        step();
        tests_run++;
        if (row !== 4'b1111) begin tests_failed++; $display("FAIL reset_row: got %b required 1111", row); end
        tests_run++;
        if (key_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b required 1", key_ready); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b required 0", busy); end
        tests_run++;
        if (contact !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("FAIL reset_contact_done: got %b%b required 00", contact, done);
        end
    endtask

    // Code 0110 = row 1, column 2: only col=1011 pulls row[1] low.
    task automatic test_row_scan();
        logic [3:0] pats [4];
        logic [3:0] exp_row;
        pats[0] = 4'b1110; pats[1] = 4'b1101; pats[2] = 4'b1011; pats[3] = 4'b0111;
        key_valid = 1'b1; key_code = 4'b0110;
        step();
        key_valid = 1'b0; key_code = 4'h0;
        for (int i = 0; i < 8; i++) begin
            col = pats[i % 4];
            #1;
            exp_row = (pats[i % 4] == 4'b1011) ? 4'b1101 : 4'b1111;
            tests_run++;
            if (row !== exp_row || contact !== 1'b1) begin
                tests_failed++;
                $display("FAIL row_scan_%0d: row=%b contact=%b required row=%b contact=1", i, row, contact, exp_row);
            end
            step();
        end
        col = 4'b1011;
        #1;
        tests_run++;
        if (row !== 4'b1111 || contact !== 1'b0) begin
            tests_failed++; $display("FAIL row_scan_released: row=%b contact=%b required 1111 0", row, contact);
        end
        col = 4'b1111;
        wait_idle("row_scan");
    endtask

    task automatic test_timing();
        logic exp_contact, exp_done, exp_ready, exp_busy;
        key_valid = 1'b1; key_code = 4'h3;
        step();
        key_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            exp_contact = (i < 8);
            exp_done    = (i == 12);
            exp_ready   = (i >= 12);
            exp_busy    = (i < 12);
            tests_run++;
            if (contact !== exp_contact || done !== exp_done || key_ready !== exp_ready || busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL timing_%0d: contact/done/ready/busy=%b%b%b%b required %b%b%b%b", i,
                         contact, done, key_ready, busy, exp_contact, exp_done, exp_ready, exp_busy);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        key_valid = 1'b1; key_code = 4'h0;
        step();
        key_code = 4'hF;
        // First press must keep code 0 (row 0, col 0) despite key_code changing.
        for (int i = 0; i < 12; i++) begin
            col = (i % 2 == 0) ? 4'b1110 : 4'b0111;
            #1;
            tests_run++;
            if (key_ready !== 1'b0) begin
                tests_failed++; $display("FAIL b2b_ready_%0d: got %b required 0", i, key_ready);
            end
            if (i < 8) begin
                tests_run++;
                if (row !== ((i % 2 == 0) ? 4'b1110 : 4'b1111)) begin
                    tests_failed++; $display("FAIL b2b_first_row_%0d: got %b col=%b", i, row, col);
                end
            end
            step();
        end
        tests_run++;
        if (done !== 1'b1 || key_ready !== 1'b1) begin
            tests_failed++; $display("FAIL b2b_done_cycle: done=%b ready=%b required 1 1", done, key_ready);
        end
        step();
        key_valid = 1'b0;
        col = 4'b0111;
        #1;
        tests_run++;
        if (contact !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || row !== 4'b0111) begin
            tests_failed++;
            $display("FAIL b2b_second: contact=%b busy=%b done=%b row=%b required 1 1 0 0111", contact, busy, done, row);
        end
        col = 4'b1111;
        wait_idle("b2b");
    endtask

    task automatic test_reset_mid();
        logic saw_activity;
        key_valid = 1'b1; key_code = 4'h5;
        step();
        key_valid = 1'b0;
        col = 4'b1101;
        step(); step();
        tests_run++;
        if (row !== 4'b1101) begin tests_failed++; $display("FAIL mid_row_before: got %b required 1101", row); end
        reset = 1'b1; key_valid = 1'b1; key_code = 4'hA;
        step();
        reset = 1'b0; key_valid = 1'b0;
        tests_run++;
        if (row !== 4'b1111 || contact !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_after_reset: row=%b contact=%b busy=%b ready=%b done=%b required 1111 0 0 1 0",
                     row, contact, busy, key_ready, done);
        end
        saw_activity = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (done || contact || busy) saw_activity = 1'b1;
        end
        tests_run++;
        if (saw_activity !== 1'b0) begin
            tests_failed++; $display("FAIL mid_quiet: activity=%b required 0", saw_activity);
        end
        col = 4'b1111;
    endtask

    task automatic test_bounce();
        logic exp_contact;
        key_valid = 1'b1; key_code = 4'h9;
        step();
        key_valid = 1'b0;
        for (int i = 0; i < 18; i++) begin
            exp_contact = (i < 8) ? ((i % 4) < 2) : (i < 16);
            tests_run++;
            if (contact !== exp_contact) begin
                tests_failed++; $display("FAIL bounce_%0d: contact=%b required %b", i, contact, exp_contact);
            end
            step();
        end
        wait_idle("bounce");
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
`ifdef KEYPAD_EMU_BOUNCE_EN
        test_bounce();
`else
        test_row_scan();
        test_timing();
        test_back_to_back();
        test_reset_mid();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
